reorder_buffer: RTL and testbench

//  In-order retirement queue; drives the commit/clear side of the register file.

---
 rtl/reorder_buffer.sv | 188 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB writeback, operand lookup and branch flush.
// Optional macro ROB_STATS_EN adds saturating commit/flush counters (stat_commits, stat_flushes).
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5,
  parameter int EMPTY_TAG = ROB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_data,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target_pc,
  input  logic [TAG_W-1:0] q_tag,
  output logic             q_ready,
  output logic [31:0]      q_data,
  output logic             if_commit,
  output logic [4:0]       pos_commit,
  output logic [31:0]      data_commit,
  output logic [TAG_W-1:0] tag_commit,
  output logic             clear,
  output logic [31:0]      clear_pc
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]      stat_commits,
  output logic [31:0]      stat_flushes
`endif
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam logic [TAG_W-1:0] EMPTY     = TAG_W'(EMPTY_TAG);
  localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(ROB_DEPTH);
  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]     head, tail;
  logic [IDX_W:0]       count;
  logic [ROB_DEPTH-1:0] ent_valid, ent_ready, ent_mis;
  logic [4:0]           ent_rd   [ROB_DEPTH];
  logic [31:0]          ent_data [ROB_DEPTH];
  logic [31:0]          ent_pc   [ROB_DEPTH];
  logic [31:0]          flush_pc;

  logic             alloc_fire, wb_fire, retire_fire, flush_fire;
  logic [IDX_W-1:0] wb_idx, q_idx;

  assign wb_idx = wb_tag[IDX_W-1:0];
  assign q_idx  = q_tag[IDX_W-1:0];

  assign alloc_ready = (count < DEPTH_CNT) && (state_q == RUN);
  assign alloc_tag   = TAG_W'(tail);

  assign alloc_fire  = rdy && alloc_valid && alloc_ready;
  assign wb_fire     = rdy && (state_q == RUN) && wb_valid && (wb_tag != EMPTY) &&
                       (wb_tag < DEPTH_TAG) && ent_valid[wb_idx];
  assign retire_fire = rdy && (state_q == RUN) && ent_valid[head] && ent_ready[head];
  assign flush_fire  = rdy && (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        RUN:     if (retire_fire && ent_mis[head]) state_d = FLUSH;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Queue control: pointers, occupancy and per-entry status bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_ready <= '0;
      ent_mis   <= '0;
    end else if (flush_fire) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_ready <= '0;
      ent_mis   <= '0;
    end else begin
      if (wb_fire) begin
        ent_ready[wb_idx] <= 1'b1;
        ent_mis[wb_idx]   <= wb_mispredict;
      end
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
        ent_mis[tail]   <= 1'b0;
        tail            <= tail + 1'b1;
      end
      if (retire_fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; only read once the matching status bit says it is meaningful
  always_ff @(posedge clk) begin
    if (alloc_fire) ent_rd[tail] <= alloc_rd;
    if (wb_fire) begin
      ent_data[wb_idx] <= wb_data;
      ent_pc[wb_idx]   <= wb_target_pc;
    end
    if (retire_fire && ent_mis[head]) flush_pc <= ent_pc[head];
  end

  // Retire and flush outputs, one cycle after the deciding edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_commit   <= 1'b0;
      pos_commit  <= '0;
      data_commit <= '0;
      tag_commit  <= EMPTY;
      clear       <= 1'b0;
      clear_pc    <= '0;
    end else begin
      if_commit <= 1'b0;
      clear     <= 1'b0;
      if (retire_fire) begin
        if_commit   <= (ent_rd[head] != 5'd0);
        pos_commit  <= ent_rd[head];
        data_commit <= ent_data[head];
        tag_commit  <= TAG_W'(head);
      end
      if (flush_fire) begin
        clear    <= 1'b1;
        clear_pc <= flush_pc;
      end
    end
  end

  always_comb begin
    q_ready = 1'b0;
    q_data  = '0;
    if ((q_tag != EMPTY) && (q_tag < DEPTH_TAG) && ent_valid[q_idx]) begin
      if (wb_valid && (wb_tag == q_tag)) begin
        q_ready = 1'b1;
        q_data  = wb_data;
      end else if (ent_ready[q_idx]) begin
        q_ready = 1'b1;
        q_data  = ent_data[q_idx];
      end
    end
  end

`ifdef ROB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_commits <= '0;
      stat_flushes <= '0;
    end else begin
      if (retire_fire) stat_commits <= sat_inc(stat_commits);
      if (flush_fire)  stat_flushes <= sat_inc(stat_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_mispredict;
  logic [31:0] wb_target_pc;
  logic [4:0]  q_tag;
  logic        q_ready;
  logic [31:0] q_data;
  logic        if_commit;
  logic [4:0]  pos_commit;
  logic [31:0] data_commit;
  logic [4:0]  tag_commit;
  logic        clear;
  logic [31:0] clear_pc;
`ifdef ROB_STATS_EN
  logic [31:0] stat_commits, stat_flushes;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
    .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data),
    .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
    .tag_commit(tag_commit), .clear(clear), .clear_pc(clear_pc)
`ifdef ROB_STATS_EN
    , .stat_commits(stat_commits), .stat_flushes(stat_flushes)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; wb_mispredict = 1'b0; wb_target_pc = '0;
    q_tag = 5'd16;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    alloc_valid = 1'b1; alloc_rd = rd;
    tick();
    alloc_valid = 1'b0; alloc_rd = '0;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [31:0] d, input logic mis, input logic [31:0] pc);
    wb_valid = 1'b1; wb_tag = tag; wb_data = d; wb_mispredict = mis; wb_target_pc = pc;
    tick();
    wb_valid = 1'b0; wb_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL reset_if_commit got=%b exp=0", if_commit); end
    total++; if (pos_commit !== 5'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos_commit); end
    total++; if (data_commit !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_commit); end
    total++; if (tag_commit !== 5'd16) begin bad++; $display("FAIL reset_tag got=%0d exp=16", tag_commit); end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b exp=0", clear); end
    total++; if (clear_pc !== 32'd0) begin bad++; $display("FAIL reset_clear_pc got=%h exp=0", clear_pc); end
    total++; if (alloc_tag !== 5'd0) begin bad++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    total++; if (q_ready !== 1'b0) begin bad++; $display("FAIL reset_q_ready got=%b exp=0", q_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_commit();
    do_reset();
    alloc(5'd5);
    wb(5'd0, 32'h1234, 1'b0, 32'd0);
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL basic_early_commit got=%b exp=0", if_commit); end
    tick();
    total++; if (if_commit !== 1'b1) begin bad++; $display("FAIL basic_if_commit got=%b exp=1", if_commit); end
    total++; if (pos_commit !== 5'd5) begin bad++; $display("FAIL basic_pos got=%0d exp=5", pos_commit); end
    total++; if (data_commit !== 32'h1234) begin bad++; $display("FAIL basic_data got=%h exp=1234", data_commit); end
    total++; if (tag_commit !== 5'd0) begin bad++; $display("FAIL basic_tag got=%0d exp=0", tag_commit); end
    tick();
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b exp=0", if_commit); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1));
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_alloc_ready got=%b exp=0", alloc_ready); end
    total++; if (alloc_tag !== 5'd0) begin bad++; $display("FAIL full_alloc_tag got=%0d exp=0", alloc_tag); end
    alloc(5'd9);
    total++; if (alloc_tag !== 5'd0) begin bad++; $display("FAIL full_ignored_tag got=%0d exp=0", alloc_tag); end
    wb(5'd0, 32'h55, 1'b0, 32'd0);
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_before_retire got=%b exp=0", alloc_ready); end
    tick();
    total++; if (if_commit !== 1'b1) begin bad++; $display("FAIL full_commit got=%b exp=1", if_commit); end
    total++; if (pos_commit !== 5'd1) begin bad++; $display("FAIL full_pos got=%0d exp=1", pos_commit); end
    total++; if (tag_commit !== 5'd0) begin bad++; $display("FAIL full_tag got=%0d exp=0", tag_commit); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b exp=1", alloc_ready); end
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(5'd3);
    alloc(5'd4);
    wb(5'd1, 32'h11, 1'b0, 32'd0);
    wb(5'd0, 32'h22, 1'b0, 32'd0);
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL order_no_early got=%b exp=0", if_commit); end
    tick();
    total++; if (if_commit !== 1'b1 || tag_commit !== 5'd0 || pos_commit !== 5'd3 || data_commit !== 32'h22) begin
      bad++; $display("FAIL order_first got=%b/%0d/%0d/%h exp=1/0/3/22", if_commit, tag_commit, pos_commit, data_commit);
    end
    tick();
    total++; if (if_commit !== 1'b1 || tag_commit !== 5'd1 || pos_commit !== 5'd4 || data_commit !== 32'h11) begin
      bad++; $display("FAIL order_second got=%b/%0d/%0d/%h exp=1/1/4/11", if_commit, tag_commit, pos_commit, data_commit);
    end
    tick();
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL order_idle got=%b exp=0", if_commit); end
  endtask

  task automatic test_lookup();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'd1);
    q_tag = 5'd3; wb_valid = 1'b1; wb_tag = 5'd3; wb_data = 32'hAA;
    #1;
    total++; if (q_ready !== 1'b1 || q_data !== 32'hAA) begin bad++; $display("FAIL lookup_bypass got=%b/%h exp=1/aa", q_ready, q_data); end
    q_tag = 5'd2;
    #1;
    total++; if (q_ready !== 1'b0) begin bad++; $display("FAIL lookup_not_ready got=%b exp=0", q_ready); end
    q_tag = 5'd3;
    tick();
    wb_valid = 1'b0; wb_data = 32'h0;
    #1;
    total++; if (q_ready !== 1'b1 || q_data !== 32'hAA) begin bad++; $display("FAIL lookup_stored got=%b/%h exp=1/aa", q_ready, q_data); end
    q_tag = 5'd16;
    #1;
    total++; if (q_ready !== 1'b0 || q_data !== 32'h0) begin bad++; $display("FAIL lookup_empty_tag got=%b/%h exp=0/0", q_ready, q_data); end
    q_tag = 5'd5;
    #1;
    total++; if (q_ready !== 1'b0 || q_data !== 32'h0) begin bad++; $display("FAIL lookup_invalid got=%b/%h exp=0/0", q_ready, q_data); end
    q_tag = 5'd16;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    wb(5'd0, 32'h77, 1'b1, 32'h100);
    wb(5'd1, 32'h88, 1'b0, 32'd0);
    total++; if (if_commit !== 1'b1 || pos_commit !== 5'd1 || data_commit !== 32'h77) begin
      bad++; $display("FAIL mis_commit got=%b/%0d/%h exp=1/1/77", if_commit, pos_commit, data_commit);
    end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL mis_clear_early got=%b exp=0", clear); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL mis_ready_in_flush got=%b exp=0", alloc_ready); end
    tick();
    total++; if (clear !== 1'b1 || clear_pc !== 32'h100) begin bad++; $display("FAIL mis_clear got=%b/%h exp=1/100", clear, clear_pc); end
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL mis_commit_width got=%b exp=0", if_commit); end
    total++; if (alloc_tag !== 5'd0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL mis_after got=%0d/%b exp=0/1", alloc_tag, alloc_ready); end
    tick();
    total++; if (clear !== 1'b0 || if_commit !== 1'b0) begin bad++; $display("FAIL mis_tag1_retired got=%b/%b exp=0/0", clear, if_commit); end
    tick();
    total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL mis_tag1_late got=%b exp=0", if_commit); end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    alloc(5'd7);
    wb(5'd0, 32'h99, 1'b0, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL stall_commit got=%b exp=0", if_commit); end
    end
    rdy = 1'b1;
    tick();
    total++; if (if_commit !== 1'b1 || pos_commit !== 5'd7 || data_commit !== 32'h99) begin
      bad++; $display("FAIL stall_release got=%b/%0d/%h exp=1/7/99", if_commit, pos_commit, data_commit);
    end
    alloc(5'd1);
    wb(5'd1, 32'h5, 1'b1, 32'h200);
    tick();
    total++; if (if_commit !== 1'b1 || tag_commit !== 5'd1) begin bad++; $display("FAIL stall_mis_commit got=%b/%0d exp=1/1", if_commit, tag_commit); end
    rdy = 1'b0;
    tick();
    total++; if (if_commit !== 1'b0 || clear !== 1'b0) begin bad++; $display("FAIL stall_flush_held got=%b/%b exp=0/0", if_commit, clear); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL stall_flush_ready got=%b exp=0", alloc_ready); end
    rdy = 1'b1;
    tick();
    total++; if (clear !== 1'b1 || clear_pc !== 32'h200) begin bad++; $display("FAIL stall_flush_clear got=%b/%h exp=1/200", clear, clear_pc); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      total++; if (alloc_tag !== 5'(i % 16)) begin bad++; $display("FAIL wrap_alloc_tag i=%0d got=%0d exp=%0d", i, alloc_tag, i % 16); end
      alloc(5'd0);
      wb(5'(i % 16), 32'(i), 1'b0, 32'd0);
      tick();
      total++; if (if_commit !== 1'b0) begin bad++; $display("FAIL wrap_rd0_commit i=%0d got=%b exp=0", i, if_commit); end
      total++; if (tag_commit !== 5'(i % 16)) begin bad++; $display("FAIL wrap_tag i=%0d got=%0d exp=%0d", i, tag_commit, i % 16); end
    end
    alloc(5'd4);
    alloc(5'd6);
    wb(5'd8, 32'h33, 1'b1, 32'h300);
    rst_n = 1'b0;
    tick();
    total++; if (if_commit !== 1'b0 || clear !== 1'b0) begin bad++; $display("FAIL midreset_pulses got=%b/%b exp=0/0", if_commit, clear); end
    total++; if (tag_commit !== 5'd16 || pos_commit !== 5'd0 || data_commit !== 32'd0 || clear_pc !== 32'd0) begin
      bad++; $display("FAIL midreset_outputs got=%0d/%0d/%h/%h exp=16/0/0/0", tag_commit, pos_commit, data_commit, clear_pc);
    end
    total++; if (alloc_tag !== 5'd0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL midreset_alloc got=%0d/%b exp=0/1", alloc_tag, alloc_ready); end
    rst_n = 1'b1;
    q_tag = 5'd8;
    tick();
    total++; if (q_ready !== 1'b0) begin bad++; $display("FAIL midreset_entries got=%b exp=0", q_ready); end
    tick();
    total++; if (clear !== 1'b0 || if_commit !== 1'b0) begin bad++; $display("FAIL midreset_no_flush got=%b/%b exp=0/0", clear, if_commit); end
    q_tag = 5'd16;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_basic_commit();
    test_full();
    test_in_order();
    test_lookup();
    test_mispredict();
    test_rdy_stall();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
